l2_req_out_packetizer: RTL and testbench

L2_REQ_OUT_PACKETIZER -- requirements
Module: l2_req_out_packetizer

---
 rtl/l2_req_out_packetizer.sv | 165 ++++++++++++++++
 tb/tb_l2_req_out_packetizer.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/l2_req_out_packetizer.sv
// Packetizes an L2 outgoing request into NoC flits: HEAD, ADDR, then one DATA
// flit per set word_mask bit for data-carrying messages.
module l2_req_out_packetizer #(
  parameter int WORDS_PER_LINE = 2,
  parameter int FLIT_W         = 66
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        l2_req_out_valid,
  output logic                        l2_req_out_ready,
  input  logic [4:0]                  coh_msg,
  input  logic [1:0]                  hprot,
  input  logic [31:0]                 addr,
  input  logic [WORDS_PER_LINE-1:0]   word_mask,
  input  logic [64*WORDS_PER_LINE-1:0] line,
  input  logic [7:0]                  src_id,
  input  logic [7:0]                  dest_id,
  output logic [FLIT_W-1:0]           noc_flit,
  output logic                        noc_flit_valid,
  input  logic                        noc_flit_ready,
  output logic [15:0]                 pkt_cnt,
  output logic [1:0]                  fsm_state
);

  localparam int WORD_BITS = (WORDS_PER_LINE > 1) ? $clog2(WORDS_PER_LINE) : 1;

  localparam logic [4:0] REQ_ODATA  = 5'd1;
  localparam logic [4:0] REQ_WT     = 5'd2;
  localparam logic [4:0] REQ_WTDATA = 5'd3;
  localparam logic [4:0] REQ_WB     = 5'd5;

  typedef enum logic [1:0] {IDLE, HEAD, ADDR, DATA} state_t;

  state_t                        state_q, state_d;
  logic [4:0]                    msg_q;
  logic [1:0]                    hprot_q;
  logic [31:0]                   addr_q;
  logic [WORDS_PER_LINE-1:0]     mask_q;
  logic [64*WORDS_PER_LINE-1:0]  line_q;
  logic [7:0]                    src_q;
  logic [7:0]                    dst_q;
  logic [WORD_BITS-1:0]          word_idx_q, word_idx_d;
  logic [WORD_BITS-1:0]          first_idx, next_idx;
  logic                          next_found;
  logic                          has_data;
  logic                          accept, xfer, tail_xfer;
  logic [63:0]                   payload;
  logic                          head_bit, tail_bit;
  logic [15:0]                   pkt_cnt_q;

  // Handshake: a beat moves on a cycle where valid & ready are both high at the
  // rising edge; a producer holding valid keeps its data stable until then.
  assign accept    = l2_req_out_valid & l2_req_out_ready;
  assign xfer      = noc_flit_valid & noc_flit_ready;
  assign has_data  = (msg_q == REQ_WT || msg_q == REQ_WB || msg_q == REQ_WTDATA ||
                      msg_q == REQ_ODATA) && (|mask_q);
  assign pkt_cnt   = pkt_cnt_q;
  assign fsm_state = state_q;

  // Lowest set mask bit overall, and lowest set bit above the current word.
  always_comb begin
    first_idx  = '0;
    next_idx   = '0;
    next_found = 1'b0;
    for (int i = WORDS_PER_LINE - 1; i >= 0; i--) begin
      if (mask_q[i]) first_idx = WORD_BITS'(i);
      if (mask_q[i] && (i > int'(word_idx_q))) begin
        next_idx   = WORD_BITS'(i);
        next_found = 1'b1;
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    word_idx_d = word_idx_q;
    tail_xfer  = 1'b0;
    case (state_q)
      IDLE: if (accept) state_d = HEAD;
      HEAD: if (xfer) state_d = ADDR;
      ADDR: if (xfer) begin
        if (has_data) begin
          state_d    = DATA;
          word_idx_d = first_idx;
        end else begin
          state_d   = IDLE;
          tail_xfer = 1'b1;
        end
      end
      DATA: if (xfer) begin
        if (next_found) begin
          word_idx_d = next_idx;
        end else begin
          state_d   = IDLE;
          tail_xfer = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Flit is built purely from registered state, so it holds still under stall.
  always_comb begin
    payload          = '0;
    head_bit         = 1'b0;
    tail_bit         = 1'b0;
    noc_flit_valid   = (state_q != IDLE);
    l2_req_out_ready = (state_q == IDLE) && !rst;
    case (state_q)
      HEAD: begin
        head_bit = 1'b1;
        payload  = {dst_q, src_q, msg_q, hprot_q, 41'd0};
        payload[WORDS_PER_LINE-1:0] = mask_q;
      end
      ADDR: begin
        tail_bit = !has_data;
        payload  = {32'd0, addr_q};
      end
      DATA: begin
        tail_bit = !next_found;
        payload  = line_q[int'(word_idx_q)*64 +: 64];
      end
      default: payload = '0;
    endcase
    noc_flit     = '0;
    noc_flit[65] = head_bit;
    noc_flit[64] = tail_bit;
    noc_flit[63:0] = payload;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      word_idx_q <= '0;
    end else begin
      state_q    <= state_d;
      word_idx_q <= word_idx_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      msg_q     <= '0;
      hprot_q   <= '0;
      addr_q    <= '0;
      mask_q    <= '0;
      line_q    <= '0;
      src_q     <= '0;
      dst_q     <= '0;
      pkt_cnt_q <= '0;
    end else begin
      if (accept) begin
        msg_q   <= coh_msg;
        hprot_q <= hprot;
        addr_q  <= addr;
        mask_q  <= word_mask;
        line_q  <= line;
        src_q   <= src_id;
        dst_q   <= dest_id;
      end
      if (tail_xfer && pkt_cnt_q != 16'hFFFF) pkt_cnt_q <= pkt_cnt_q + 16'd1;
    end
  end

endmodule

// File: tb/tb_l2_req_out_packetizer.sv
// Scoreboard bench for l2_req_out_packetizer: a packet-level model queues the
// expected flits, a monitor pops them on every NoC transfer.
module tb_l2_req_out_packetizer;

  localparam logic [4:0] M_REQ_S      = 5'd0;
  localparam logic [4:0] M_REQ_ODATA  = 5'd1;
  localparam logic [4:0] M_REQ_WT     = 5'd2;
  localparam logic [4:0] M_REQ_WTDATA = 5'd3;
  localparam logic [4:0] M_REQ_WB     = 5'd5;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         l2_req_out_valid = 1'b0;
  logic         l2_req_out_ready;
  logic [4:0]   coh_msg = '0;
  logic [1:0]   hprot = '0;
  logic [31:0]  addr = '0;
  logic [1:0]   word_mask = '0;
  logic [127:0] line = '0;
  logic [7:0]   src_id = '0;
  logic [7:0]   dest_id = '0;
  logic [65:0]  noc_flit;
  logic         noc_flit_valid;
  logic         noc_flit_ready = 1'b0;
  logic [15:0]  pkt_cnt;
  logic [1:0]   fsm_state;

  logic [65:0]  exp_q[$];
  int           checks = 0;
  int           errors = 0;
  logic [15:0]  exp_cnt = '0;
  int           rdy_mode = 0;
  bit           manual = 1'b0;

  l2_req_out_packetizer #(.WORDS_PER_LINE(2), .FLIT_W(66)) dut (
    .clk(clk), .rst(rst),
    .l2_req_out_valid(l2_req_out_valid), .l2_req_out_ready(l2_req_out_ready),
    .coh_msg(coh_msg), .hprot(hprot), .addr(addr), .word_mask(word_mask),
    .line(line), .src_id(src_id), .dest_id(dest_id),
    .noc_flit(noc_flit), .noc_flit_valid(noc_flit_valid),
    .noc_flit_ready(noc_flit_ready), .pkt_cnt(pkt_cnt), .fsm_state(fsm_state)
  );

  // Clock / reset
  always #5 clk = ~clk;

  task automatic chk(input bit ok, input string name, input logic [65:0] act,
                     input logic [65:0] req);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, req, $time);
    end
  endtask

  // Reference model: the packet as a list of flits.
  task automatic push_expected(input logic [4:0] m, input logic [1:0] hp,
                               input logic [31:0] a, input logic [1:0] wm,
                               input logic [127:0] ln, input logic [7:0] s,
                               input logic [7:0] d);
    logic [65:0] f[$];
    logic [65:0] last;
    bit carries;
    f.push_back({1'b1, 1'b0, d, s, m, hp, 39'd0, wm});
    f.push_back({1'b0, 1'b0, 32'd0, a});
    carries = (m == M_REQ_WT || m == M_REQ_WB || m == M_REQ_WTDATA || m == M_REQ_ODATA)
              && (wm != 2'b00);
    if (carries)
      for (int w = 0; w < 2; w++)
        if (wm[w]) f.push_back({2'b00, ln[64*w +: 64]});
    last = f.pop_back();
    last[64] = 1'b1;
    f.push_back(last);
    foreach (f[k]) exp_q.push_back(f[k]);
  endtask

  // NoC ready driver
  always @(posedge clk) begin
    #1;
    if (!manual) begin
      case (rdy_mode)
        0: noc_flit_ready = 1'b1;
        1: noc_flit_ready = ~noc_flit_ready;
        default: noc_flit_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // Driver
  task automatic send_pkt(input logic [4:0] m, input logic [1:0] hp,
                          input logic [31:0] a, input logic [1:0] wm,
                          input logic [127:0] ln, input logic [7:0] s,
                          input logic [7:0] d);
    int budget = 0;
    @(negedge clk);
    push_expected(m, hp, a, wm, ln, s, d);
    coh_msg = m; hprot = hp; addr = a; word_mask = wm; line = ln;
    src_id = s; dest_id = d; l2_req_out_valid = 1'b1;
    while (!l2_req_out_ready && budget < 300) begin
      @(negedge clk);
      budget++;
    end
    if (budget >= 300) begin
      chk(1'b0, "accept_timeout", 66'(l2_req_out_ready), 66'd1);
      l2_req_out_valid = 1'b0;
      return;
    end
    @(negedge clk);
    l2_req_out_valid = 1'b0;
    coh_msg = 5'($urandom); addr = $urandom; word_mask = 2'($urandom);
    line = {$urandom, $urandom, $urandom, $urandom};
    src_id = 8'($urandom); dest_id = 8'($urandom); hprot = 2'($urandom);
    chk(noc_flit_valid == 1'b1, "head_latency", 66'(noc_flit_valid), 66'd1);
  endtask

  task automatic send_rand(input logic [4:0] m, input logic [1:0] wm);
    send_pkt(m, 2'($urandom), $urandom, wm, {$urandom, $urandom, $urandom, $urandom},
             8'($urandom), 8'($urandom));
  endtask

  task automatic wait_drain();
    int budget = 0;
    while ((exp_q.size() != 0 || noc_flit_valid) && budget < 500) begin
      @(negedge clk);
      budget++;
    end
    chk(budget < 500, "drain_timeout", 66'(exp_q.size()), 66'd0);
  endtask

  // Monitor / scoreboard
  logic [65:0] held_flit;
  bit          stalled = 1'b0;
  bit          post_tail = 1'b0;
  always @(negedge clk) begin
    if (rst) begin
      stalled   = 1'b0;
      post_tail = 1'b0;
    end else begin
      if (post_tail) begin
        chk(!noc_flit_valid && l2_req_out_ready, "idle_gap",
            {64'd0, noc_flit_valid, l2_req_out_ready}, 66'b01);
        chk(pkt_cnt == exp_cnt, "pkt_cnt", 66'(pkt_cnt), 66'(exp_cnt));
        post_tail = 1'b0;
      end
      if (stalled)
        chk(noc_flit_valid && noc_flit == held_flit, "stall_stable", noc_flit, held_flit);
      if (noc_flit_valid)
        chk(!l2_req_out_ready, "busy_ready", 66'(l2_req_out_ready), 66'd0);
      if (noc_flit_valid && noc_flit_ready) begin
        if (exp_q.size() == 0) begin
          chk(1'b0, "unexpected_flit", noc_flit, 66'd0);
        end else begin
          logic [65:0] e;
          e = exp_q.pop_front();
          chk(noc_flit == e, "flit", noc_flit, e);
          if (e[64]) begin
            post_tail = 1'b1;
            if (exp_cnt != 16'hFFFF) exp_cnt = exp_cnt + 16'd1;
          end
        end
        stalled = 1'b0;
      end else if (noc_flit_valid) begin
        stalled   = 1'b1;
        held_flit = noc_flit;
      end else begin
        stalled = 1'b0;
      end
    end
  end

  initial begin
    int n;
    // Reset state
    repeat (3) @(negedge clk);
    chk(!l2_req_out_ready && !noc_flit_valid && noc_flit == 66'd0 && pkt_cnt == 16'd0,
        "reset_state", {noc_flit[63:0] ^ {48'd0, pkt_cnt}, l2_req_out_ready, noc_flit_valid}, 66'd0);
    @(negedge clk);
    #2 rst = 1'b0;
    @(negedge clk);
    chk(l2_req_out_ready == 1'b1, "ready_after_reset", 66'(l2_req_out_ready), 66'd1);

    // Read request, no data
    rdy_mode = 0;
    send_pkt(M_REQ_S, 2'b00, 32'h0000_1240, 2'b11, {64'h1111, 64'h2222}, 8'h01, 8'h03);
    wait_drain();
    chk(pkt_cnt == 16'd1, "pkt_cnt_first", 66'(pkt_cnt), 66'd1);

    // Writeback, both words, back-to-back valid cycles
    send_pkt(M_REQ_WB, 2'b01, 32'h0000_2000, 2'b11, {64'hBBBB, 64'hAAAA}, 8'h02, 8'h04);
    n = 1;
    while (noc_flit_valid && n < 20) begin
      @(negedge clk);
      if (noc_flit_valid) n++;
    end
    chk(n == 4, "wb_valid_cycles", 66'(n), 66'd4);
    wait_drain();

    // Write-through, upper word only
    send_pkt(M_REQ_WT, 2'b10, 32'h0000_3000, 2'b10, {64'hDDDD, 64'hCCCC}, 8'h05, 8'h06);
    wait_drain();

    // Data message with empty mask carries no data
    send_rand(M_REQ_WTDATA, 2'b00);
    wait_drain();

    // Stalling NoC: ready toggles every cycle
    rdy_mode = 1;
    send_pkt(M_REQ_WB, 2'b11, 32'h0000_4000, 2'b11, {64'h5555, 64'h4444}, 8'h07, 8'h08);
    wait_drain();

    // Randomized packets, back to back, random NoC backpressure
    rdy_mode = 2;
    for (int k = 0; k < 25; k++) begin
      logic [4:0] m;
      case ($urandom_range(0, 5))
        0: m = M_REQ_S;
        1: m = M_REQ_WT;
        2: m = M_REQ_WB;
        3: m = M_REQ_WTDATA;
        4: m = M_REQ_ODATA;
        default: m = 5'($urandom);
      endcase
      send_rand(m, 2'($urandom));
    end
    wait_drain();

    // Reset in the middle of the ADDR flit
    manual = 1'b1;
    noc_flit_ready = 1'b0;
    send_pkt(M_REQ_WB, 2'b00, 32'h0000_5000, 2'b11, {64'h7777, 64'h6666}, 8'h09, 8'h0A);
    @(posedge clk); #1 noc_flit_ready = 1'b1;
    @(posedge clk); #1 noc_flit_ready = 1'b0;
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk(!noc_flit_valid && pkt_cnt == 16'd0 && !l2_req_out_ready && noc_flit == 66'd0,
        "mid_packet_reset", {noc_flit[63:0] ^ {48'd0, pkt_cnt}, l2_req_out_ready, noc_flit_valid}, 66'd0);
    exp_q.delete();
    exp_cnt = '0;
    @(negedge clk);
    #2 rst = 1'b0;
    manual = 1'b0;
    rdy_mode = 0;
    @(negedge clk);
    chk(l2_req_out_ready == 1'b1, "ready_after_abort", 66'(l2_req_out_ready), 66'd1);
    send_pkt(M_REQ_S, 2'b01, 32'h0000_6000, 2'b01, 128'd0, 8'h0B, 8'h0C);
    wait_drain();

    // Counter saturation
    @(negedge clk);
    force dut.pkt_cnt_q = 16'hFFFE;
    @(negedge clk);
    release dut.pkt_cnt_q;
    exp_cnt = 16'hFFFE;
    for (int k = 0; k < 3; k++) send_rand(M_REQ_S, 2'($urandom));
    wait_drain();
    @(negedge clk);
    chk(pkt_cnt == 16'hFFFF, "pkt_cnt_saturate", 66'(pkt_cnt), 66'hFFFF);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Global time bound
  initial begin
    #2_000_000;
    $display("FAIL global_timeout actual=running required=finished");
    errors++;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "timeout");
  end

endmodule
